// File: rtl/ul_fir_pkg.sv
// Shared helpers for the symmetric linear-phase FIR: clog2, pipeline latency,
// datapath width rules and adder-tree level sizing.
package ul_fir_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Input sample to data_valid_o, in clock cycles.
    function automatic int latency(input int nof_coeffs);
        return 3 + clog2(nof_coeffs);
    endfunction

    // One extra bit so the sum of two samples never wraps.
    function automatic int preadd_width(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int product_width(input int data_width, input int coeff_width);
        return preadd_width(data_width) + coeff_width;
    endfunction

    // Growth of clog2(n) bits covers the sum of n products.
    function automatic int acc_width(input int data_width, input int coeff_width,
                                     input int nof_coeffs);
        return product_width(data_width, coeff_width) + clog2(nof_coeffs);
    endfunction

    // Number of live nodes after 'level' pairwise reductions of 'count' inputs.
    function automatic int tree_count(input int count, input int level);
        return (count + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/ul_fir_adder_tree.sv
// Registered binary reduction of COUNT signed operands. Every level is
// registered; an odd operand passes through its level with a register so all
// paths have the same depth. DEPTH reports the number of register levels.
module ul_fir_adder_tree
    import ul_fir_pkg::*;
#(
    parameter int COUNT     = 16,
    parameter int IN_WIDTH  = 33,
    parameter int OUT_WIDTH = 37
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [COUNT*IN_WIDTH-1:0]   in_i,
    output logic signed [OUT_WIDTH-1:0] sum_o
);

    localparam int DEPTH = clog2(COUNT);
    localparam int HALF  = (COUNT + 1) / 2;

    // Upper operand of pair i, clamped so an unpaired node never indexes past the end.
    function automatic int hi_idx(input int i);
        return (2 * i + 1 < COUNT) ? 2 * i + 1 : COUNT - 1;
    endfunction

    logic signed [OUT_WIDTH-1:0] in_ext [COUNT];
    logic signed [OUT_WIDTH-1:0] lvl_in [DEPTH][COUNT];
    logic signed [OUT_WIDTH-1:0] lvl_q  [DEPTH][HALF];

    genvar gi;
    generate
        for (gi = 0; gi < COUNT; gi++) begin : g_ext
            assign in_ext[gi] = {{(OUT_WIDTH - IN_WIDTH){in_i[gi*IN_WIDTH + IN_WIDTH - 1]}},
                                 in_i[gi*IN_WIDTH +: IN_WIDTH]};
        end
    endgenerate

    // Operand view of each level: level 0 is the input, later levels the previous registers.
    always_comb begin
        for (int l = 0; l < DEPTH; l++) begin
            for (int j = 0; j < COUNT; j++) begin
                lvl_in[l][j] = '0;
            end
        end
        for (int j = 0; j < COUNT; j++) begin
            lvl_in[0][j] = in_ext[j];
        end
        for (int l = 1; l < DEPTH; l++) begin
            for (int j = 0; j < HALF; j++) begin
                lvl_in[l][j] = lvl_q[l-1][j];
            end
        end
    end

    // Pairwise sums per level; odd leftovers are re-registered, dead nodes stay zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int l = 0; l < DEPTH; l++) begin
                for (int i = 0; i < HALF; i++) begin
                    lvl_q[l][i] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < DEPTH; l++) begin
                for (int i = 0; i < HALF; i++) begin
                    if (2 * i + 1 < tree_count(COUNT, l)) begin
                        lvl_q[l][i] <= lvl_in[l][2*i] + lvl_in[l][hi_idx(i)];
                    end else if (2 * i < tree_count(COUNT, l)) begin
                        lvl_q[l][i] <= lvl_in[l][2*i];
                    end else begin
                        lvl_q[l][i] <= '0;
                    end
                end
            end
        end
    end

    assign sum_o = lvl_q[DEPTH-1][0];

endmodule

// File: rtl/ul_fir_linphase.sv
// Symmetric linear-phase FIR, 2*NOF_COEFFS-1 taps, one sample per clock.
// Pipeline: delay line + pre-add, multiply, adder tree, round/saturate.
// Build option: define UL_FIR_ROUND_EN for round-half-up before the final
// shift; otherwise the shift floors.
module ul_fir_linphase
    import ul_fir_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int COEFF_WIDTH      = 16,
    parameter int COEFF_FRAC_WIDTH = 14,
    parameter int NOF_COEFFS       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic signed [DATA_WIDTH-1:0]      data_i,
    input  logic                              data_valid_i,
    input  logic [NOF_COEFFS*COEFF_WIDTH-1:0] coeffs_i,
    output logic signed [DATA_WIDTH-1:0]      data_o,
    output logic                              data_valid_o,
    output logic                              overflow_o
);

    localparam int NTAPS = 2 * NOF_COEFFS - 1;
    localparam int PW    = preadd_width(DATA_WIDTH);
    localparam int MW    = product_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int AW    = acc_width(DATA_WIDTH, COEFF_WIDTH, NOF_COEFFS);
    localparam int LAT   = latency(NOF_COEFFS);

    localparam logic signed [AW-1:0] OUT_MAX = AW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [DATA_WIDTH-1:0]  x_q   [NTAPS];
    logic signed [DATA_WIDTH-1:0]  x_d   [NTAPS];
    logic signed [PW-1:0]          p_d   [NOF_COEFFS];
    logic signed [PW-1:0]          p_q   [NOF_COEFFS];
    logic signed [COEFF_WIDTH-1:0] coeff [NOF_COEFFS];
    logic signed [MW-1:0]          m_q   [NOF_COEFFS];
    logic [NOF_COEFFS*MW-1:0]      m_flat;
    logic signed [AW-1:0]          tree_sum;
    logic signed [AW-1:0]          acc_rnd;
    logic signed [AW-1:0]          acc_shift;
    logic signed [DATA_WIDTH-1:0]  data_d;
    logic                          sat_d;
    logic signed [DATA_WIDTH-1:0]  data_q;
    logic                          ovf_q;
    logic [LAT-1:0]                vld_q;

    genvar gi;
    generate
        // Delay line next state: shift on a valid sample, hold history otherwise.
        for (gi = 0; gi < NTAPS; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign x_d[gi] = data_valid_i ? data_i : x_q[gi];
            end else begin : g_body
                assign x_d[gi] = data_valid_i ? x_q[gi-1] : x_q[gi];
            end
        end

        // Fold mirror taps; the centre tap is taken alone. Pre-add works on the
        // updated window so the delay line and pre-add share one register stage.
        for (gi = 0; gi < NOF_COEFFS; gi++) begin : g_pre
            if (gi < NOF_COEFFS - 1) begin : g_pair
                assign p_d[gi] = $signed({x_d[gi][DATA_WIDTH-1], x_d[gi]})
                               + $signed({x_d[NTAPS-1-gi][DATA_WIDTH-1], x_d[NTAPS-1-gi]});
            end else begin : g_centre
                assign p_d[gi] = $signed({x_d[gi][DATA_WIDTH-1], x_d[gi]});
            end
            assign coeff[gi] = $signed(coeffs_i[gi*COEFF_WIDTH +: COEFF_WIDTH]);
            assign m_flat[gi*MW +: MW] = m_q[gi];
        end
    endgenerate

    // Delay line and pre-add registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < NOF_COEFFS; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= x_d[k];
            end
            for (int k = 0; k < NOF_COEFFS; k++) begin
                p_q[k] <= p_d[k];
            end
        end
    end

    // Multiply stage; all coefficients are captured in the same cycle, so one
    // output never mixes two coefficient sets.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NOF_COEFFS; k++) begin
                m_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NOF_COEFFS; k++) begin
                m_q[k] <= MW'(p_q[k]) * MW'(coeff[k]);
            end
        end
    end

    ul_fir_adder_tree #(
        .COUNT     (NOF_COEFFS),
        .IN_WIDTH  (MW),
        .OUT_WIDTH (AW)
    ) u_tree (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (m_flat),
        .sum_o (tree_sum)
    );

    // Scale back to sample units and clamp to the output range.
    always_comb begin
`ifdef UL_FIR_ROUND_EN
        acc_rnd = tree_sum + (AW'(1) <<< (COEFF_FRAC_WIDTH - 1));
`else
        acc_rnd = tree_sum;
`endif
        acc_shift = acc_rnd >>> COEFF_FRAC_WIDTH;
        data_d    = acc_shift[DATA_WIDTH-1:0];
        sat_d     = 1'b0;
        if (acc_shift > OUT_MAX) begin
            data_d = OUT_MAX[DATA_WIDTH-1:0];
            sat_d  = 1'b1;
        end else if (acc_shift < OUT_MIN) begin
            data_d = OUT_MIN[DATA_WIDTH-1:0];
            sat_d  = 1'b1;
        end
    end

    // Output register and valid pipe; overflow is only flagged on valid slots.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            ovf_q  <= sat_d & vld_q[LAT-2];
            vld_q  <= {vld_q[LAT-2:0], data_valid_i};
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = vld_q[LAT-1];
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ul_fir_linphase.sv
// Scoreboard bench for ul_fir_linphase at default parameters. Stimulus pushes
// hand-computed expected outputs; a negedge monitor pops and checks value,
// overflow flag and per-sample latency.
module tb_ul_fir_linphase;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int N   = 16;
    localparam int LAT = 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic signed [DW-1:0]   data_i = '0;
    logic                   valid_i = 1'b0;
    logic [N*CW-1:0]        coeffs = '0;
    logic signed [DW-1:0]   data_o;
    logic                   valid_o;
    logic                   ovf_o;

    ul_fir_linphase #(
        .DATA_WIDTH       (DW),
        .COEFF_WIDTH      (CW),
        .COEFF_FRAC_WIDTH (14),
        .NOF_COEFFS       (N)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data_i),
        .data_valid_i (valid_i),
        .coeffs_i     (coeffs),
        .data_o       (data_o),
        .data_valid_o (valid_o),
        .overflow_o   (ovf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int data;
        bit ovf;
        int cyc;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    out_idx = 0;
    string cur_test = "reset";

    // Monitor: every valid output is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected_output data_o=%0d overflow_o=%0d required no valid output",
                         cur_test, data_o, ovf_o);
            end else begin
                e = sb.pop_front();
                if (int'(data_o) != e.data || ovf_o != e.ovf || (cyc - e.cyc) != LAT) begin
                    n_fail++;
                    $display("FAIL %s out[%0d] data_o=%0d overflow_o=%0d latency=%0d required data_o=%0d overflow_o=%0d latency=%0d",
                             cur_test, out_idx, data_o, ovf_o, cyc - e.cyc, e.data, e.ovf, LAT);
                end
            end
            out_idx++;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input int val, input bit v, input bit push, input int exp_d, input bit exp_o);
        exp_t e;
        @(posedge clk);
        #1;
        data_i  = DW'(val);
        valid_i = v;
        if (v && push) begin
            e.data = exp_d;
            e.ovf  = exp_o;
            e.cyc  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain_timeout pending=%0d required 0", cur_test, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset(input string next_test);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cur_test = next_test;
        out_idx  = 0;
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < N; k++) coeffs[k*CW +: CW] = CW'(v);
    endtask

    task automatic set_centre(input int v);
        set_all(0);
        coeffs[(N-1)*CW +: CW] = CW'(v);
    endtask

    // Impulse 1000 through a unity centre tap: appears after 15 samples only.
    task automatic run_identity();
        for (int n = 0; n < 30; n++)
            send((n == 0) ? 1000 : 0, 1'b1, 1'b1, (n == 15) ? 1000 : 0, 1'b0);
        drain();
    endtask

    initial begin
        int r3;
        int rm3;
        int n;
        int c;
`ifdef UL_FIR_ROUND_EN
        r3  = 2;
        rm3 = -1;
`else
        r3  = 1;
        rm3 = -2;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_o", int'(data_o), 0);
        check("reset_data_valid_o", int'(valid_o), 0);
        check("reset_overflow_o", int'(ovf_o), 0);

        // Identity
        cur_test = "identity";
        set_centre(16384);
        run_identity();

        // DC gain: step response ramps 100 per sample to 3100
        do_reset("dc_gain");
        set_all(1024);
        for (int k = 0; k < 40; k++)
            send(1600, 1'b1, 1'b1, 100 * ((k + 1 < 31) ? k + 1 : 31), 1'b0);
        drain();

        // Impulse response: 31 taps of 100
        do_reset("impulse_31");
        for (int k = 0; k < 35; k++)
            send((k == 0) ? 1600 : 0, 1'b1, 1'b1, (k < 31) ? 100 : 0, 1'b0);
        drain();

        // Saturation high, low, and zero input
        do_reset("sat_pos");
        set_all(16384);
        for (int k = 0; k < 5; k++) send(32767, 1'b1, 1'b1, 32767, k > 0);
        drain();
        do_reset("sat_neg");
        for (int k = 0; k < 5; k++) send(-32768, 1'b1, 1'b1, -32768, k > 0);
        drain();
        do_reset("sat_zero");
        for (int k = 0; k < 5; k++) send(0, 1'b1, 1'b1, 0, 1'b0);
        drain();

        // Rounding of +/-1.5
        do_reset("rounding");
        set_centre(8192);
        for (int k = 0; k < 17; k++)
            send((k == 0) ? 3 : (k == 1) ? -3 : 0, 1'b1, 1'b1,
                 (k == 15) ? r3 : (k == 16) ? rm3 : 0, 1'b0);
        drain();

        // Valid gaps 1,0,0,1,1,0 with a ramp through the centre tap
        do_reset("gaps");
        set_centre(16384);
        n = 0;
        c = 0;
        while (n < 25) begin
            if ((c % 6) == 0 || (c % 6) == 3 || (c % 6) == 4) begin
                send(10 * (n + 1), 1'b1, 1'b1, (n < 15) ? 0 : 10 * (n - 14), 1'b0);
                n++;
            end else begin
                send(12345, 1'b0, 1'b0, 0, 1'b0);
            end
            c++;
        end
        drain();

        // Coefficient swap 1/16 -> 2/16 mid-stream on a constant input
        do_reset("coeff_swap");
        set_all(1024);
        for (int k = 0; k < 60; k++) begin
            exp_t e;
            @(posedge clk);
            #1;
            if (k == 40) set_all(2048);
            data_i  = DW'(1600);
            valid_i = 1'b1;
            e.data  = (k >= 39) ? 6200 : 100 * ((k + 1 < 31) ? k + 1 : 31);
            e.ovf   = 1'b0;
            e.cyc   = cyc;
            sb.push_back(e);
        end
        drain();

        // Reset with five samples in flight: none may emerge
        do_reset("reset_midstream");
        set_centre(16384);
        for (int k = 0; k < 5; k++) send((k == 0) ? 1000 : 0, 1'b1, 1'b0, 0, 1'b0);
        do_reset("reset_midstream");
        @(negedge clk);
        check("midreset_data_o", int'(data_o), 0);
        check("midreset_data_valid_o", int'(valid_o), 0);
        repeat (12) @(posedge clk);
        cur_test = "identity_after_reset";
        out_idx  = 0;
        run_identity();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ul_fir_linphase.md
Name: ul_fir_linphase

Overview:
- Symmetric linear-phase FIR datapath. Consumes the flattened coefficient bus from the coefficient memory.
- Filter length is 2*NOF_COEFFS-1 taps. coeff[NOF_COEFFS-1] is the centre tap; coeff[k] weights tap k and its mirror tap 2*NOF_COEFFS-2-k.
- Processes one sample per clock with a valid qualifier. Fully pipelined, no backpressure.
- Sits between the ADC sample path and downstream user logic.

Parameters:
- DATA_WIDTH, 16: signed sample width, input and output.
- COEFF_WIDTH, 16: signed coefficient width.
- COEFF_FRAC_WIDTH, 14: fractional bits of each coefficient.
- NOF_COEFFS, 16: number of unique coefficients; range 2..64.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset.
- data_i, input, DATA_WIDTH: signed input sample.
- data_valid_i, input, 1: data_i is valid this cycle.
- coeffs_i, input, NOF_COEFFS*COEFF_WIDTH: coeff k at bits [k*COEFF_WIDTH +: COEFF_WIDTH].
- data_o, output, DATA_WIDTH: signed filtered sample.
- data_valid_o, output, 1: data_o is valid.
- overflow_o, output, 1: saturation occurred on the current data_o; one-cycle pulse.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: delay line, all pipeline registers and the valid pipe clear to 0. After reset, data_o=0, data_valid_o=0, overflow_o=0.
- Reset mid-stream: samples in flight are discarded and no valid output is produced for them. Filter history restarts from zeros.
- Delay line:
  - 2*NOF_COEFFS-1 samples, x[0] newest.
  - Shifts only when data_valid_i=1. Idle cycles hold the history.
- Stage 1, pre-add (registered):
  - p[k] = x[k] + x[2N-2-k] for k < N-1.
  - p[N-1] = x[N-1], not doubled.
  - Width DATA_WIDTH+1, sign-extended.
- Stage 2, multiply (registered):
  - m[k] = p[k] * coeff[k], signed.
  - Width DATA_WIDTH+1+COEFF_WIDTH.
  - coeffs_i is sampled here every cycle. A coefficient update therefore applies atomically from one output sample to the next, with no mixed sets.
- Adder tree:
  - clog2(NOF_COEFFS) registered pairwise stages. An odd element passes through with a register.
  - Accumulator width is the product width + clog2(NOF_COEFFS); the sum never wraps.
- Final stage (registered):
  - With UL_FIR_ROUND_EN (see Optional Feature), add 2^(COEFF_FRAC_WIDTH-1), then arithmetic shift right by COEFF_FRAC_WIDTH.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]. overflow_o=1 when clamping occurs, qualified by valid.
- Latency: LATENCY = 3 + clog2(NOF_COEFFS); 7 at defaults.
  - data_valid_i is carried through a LATENCY-deep shift register. data_valid_o at cycle t+LATENCY corresponds to the sample accepted at cycle t.
- Gaps: the pipeline free-runs every cycle. Non-valid slots propagate as data_valid_o=0. data_o is don't-care when not valid, but must be deterministic.
- Back-to-back valid input gives back-to-back valid output.
- Group delay is N-1 samples; it counts samples, not cycles.

Optional Feature:
- Macro: UL_FIR_ROUND_EN.
- Defined: round half toward +inf before the shift.
- Undefined: plain arithmetic shift (floor), with no rounding adder.
- Latency and saturation are identical in both builds.

Decomposition:
- Package ul_fir_pkg holds:
  - clog2 function;
  - LATENCY function of NOF_COEFFS;
  - width helpers (pre-add, product, accumulator).
- Sub-module ul_fir_adder_tree: parameterised count and width, registered binary reduction, reports its own depth.
- The top level holds the delay line, pre-add, multipliers, round/saturate and valid pipe.

Test Plan:
All cases use defaults: N=16, F=14, DW=16.
1. Identity: coeffs all 0 except coeff[15]=16384; feed impulse 1000 then zeros, continuously valid -> data_o=1000 on the 16th valid output (group delay 15), all others 0; data_valid_o rises 7 cycles after the first data_valid_i.
2. Symmetry/DC gain: all coeffs=1024 (1/16); constant 1600 for 40 samples -> steady-state data_o=3100 (1600*31/16); impulse response is 31 taps, each 100.
3. Saturation:
   - All coeffs=16384; constant 32767 -> data_o=32767 with overflow_o=1.
   - Constant -32768 -> data_o=-32768 with overflow_o=1.
   - Input 0 -> overflow_o=0.
4. Rounding: coeff[15]=8192 only; input 3 -> 2 (ROUND_EN) or 1 (without); input -3 -> -1 (ROUND_EN) or -2 (without).
5. Valid gaps and coefficient swap:
   - Valid pattern 1,0,0,1,1,0 repeating -> output sample sequence identical to the gapless case, each output 7 cycles after its input.
   - Change coeffs_i in one cycle mid-stream -> each output entirely uses the old set or the new set.
6. Reset mid-stream: assert rst_i for 1 cycle with 5 samples in flight -> no data_valid_o for them; data_o=0; the next impulse reproduces case 1 from zero history.
